abs_diff_sequencer: RTL and testbench

ABS_DIFF_SEQUENCER -- requirements
Module: abs_diff_sequencer

---
 rtl/abs_diff_sequencer.sv | 145 ++++++++++++++
 tb/tb_abs_diff_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/abs_diff_sequencer.sv
// Sequential |A-B| unit: two bits per cycle through one 2-bit add slice, negating on borrow.
// Optional ABS_DIFF_EQ_SHORTCUT_EN sends equal operands straight to DONE.
module abs_diff_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             sign
);

  localparam int unsigned Slices = WIDTH / 2;
  localparam int unsigned IdxW   = (Slices > 1) ? $clog2(Slices) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Slices - 1);

  typedef enum logic [2:0] {StIdle, StSub, StChk, StNeg, StDone} stateE;

  stateE            stateQ, stateD;
  logic [IdxW-1:0]  idxQ, idxD;
  logic             carryQ, carryD;
  logic [WIDTH-1:0] aQ, aD, bQ, bD, dQ, dD;
  logic [WIDTH-1:0] resultQ, resultD;
  logic             signQ, signD;

  logic [1:0]       opX, opY;
  logic [2:0]       sliceSum;
  logic [WIDTH-1:0] dShift;

  // Operands shift right as slices are consumed; D fills from the top, so the
  // active slice is always bit pair [1:0].
  always_comb begin
    opX = aQ[1:0];
    opY = ~bQ[1:0];
    if (stateQ == StNeg) begin
      opX = ~dQ[1:0];
      opY = 2'b00;
    end
  end

  assign sliceSum = {1'b0, opX} + {1'b0, opY} + {2'b00, carryQ};
  assign dShift   = WIDTH'({sliceSum[1:0], dQ} >> 2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= StIdle;
      idxQ    <= '0;
      carryQ  <= 1'b0;
      aQ      <= '0;
      bQ      <= '0;
      dQ      <= '0;
      resultQ <= '0;
      signQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      idxQ    <= idxD;
      carryQ  <= carryD;
      aQ      <= aD;
      bQ      <= bD;
      dQ      <= dD;
      resultQ <= resultD;
      signQ   <= signD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    idxD    = idxQ;
    carryD  = carryQ;
    aD      = aQ;
    bD      = bQ;
    dD      = dQ;
    resultD = resultQ;
    signD   = signQ;
    unique case (stateQ)
      StIdle, StDone: begin
        if (start) begin
          aD     = A;
          bD     = B;
          carryD = 1'b1;
          idxD   = '0;
          stateD = StSub;
`ifdef ABS_DIFF_EQ_SHORTCUT_EN
          if (A == B) begin
            stateD  = StDone;
            resultD = '0;
            signD   = 1'b0;
          end
`endif
        end else begin
          stateD = StIdle;
        end
      end
      StSub: begin
        aD     = aQ >> 2;
        bD     = bQ >> 2;
        dD     = dShift;
        carryD = sliceSum[2];
        idxD   = idxQ + 1'b1;
        if (idxQ == LastIdx) stateD = StChk;
      end
      StChk: begin
        // Final carry out of A + ~B + 1 is set exactly when no borrow, i.e. A >= B.
        if (carryQ) begin
          stateD  = StDone;
          resultD = dQ;
          signD   = 1'b0;
        end else begin
          stateD = StNeg;
          carryD = 1'b1;
          idxD   = '0;
        end
      end
      StNeg: begin
        dD     = dShift;
        carryD = sliceSum[2];
        idxD   = idxQ + 1'b1;
        if (idxQ == LastIdx) begin
          stateD  = StDone;
          resultD = dShift;
          signD   = 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (stateQ)
      StSub, StChk, StNeg: busy = 1'b1;
      StDone:              done = 1'b1;
      default:             ;
    endcase
  end

  assign result = resultQ;
  assign sign   = signQ;

endmodule

// File: tb/tb_abs_diff_sequencer.sv
// Self-checking bench for abs_diff_sequencer: latency/result model plus directed and random runs.
module tb_abs_diff_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] A, B;
  logic         busy, done, sign;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;
  bit chkEn = 1'b0;

  abs_diff_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result),
    .sign   (sign)
  );

  always #5 clk = ~clk;

  // Reference model: tracks cycles remaining until done, computes |A-B| arithmetically.
  int rem = 0;
  int aM = 0, bM = 0, resM = 0, signM = 0, busyM = 0, doneM = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      rem = 0; busyM = 0; doneM = 0; resM = 0; signM = 0;
    end else if (start && busyM == 0) begin
      aM = int'(A);
      bM = int'(B);
      doneM = 0;
`ifdef ABS_DIFF_EQ_SHORTCUT_EN
      if (aM == bM) begin
        doneM = 1; busyM = 0; resM = 0; signM = 0;
      end else begin
        rem = (aM >= bM) ? W / 2 + 1 : W + 1;
        busyM = 1;
      end
`else
      rem = (aM >= bM) ? W / 2 + 1 : W + 1;
      busyM = 1;
`endif
    end else if (busyM != 0) begin
      rem--;
      if (rem == 0) begin
        busyM = 0;
        doneM = 1;
        resM  = (aM >= bM) ? aM - bM : bM - aM;
        signM = (aM < bM) ? 1 : 0;
      end
    end else begin
      doneM = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      check("cmp_busy", 32'(busy), 32'(busyM));
      check("cmp_done", 32'(done), 32'(doneM));
      check("cmp_result", 32'(result), 32'(resM));
      check("cmp_sign", 32'(sign), 32'(signM));
    end
  end

  task automatic doStart(input int a, input int b);
    start = 1'b1;
    A = W'(a);
    B = W'(b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busyCnt++;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_done timeout got=0 exp=1");
    end
  endtask

  task automatic runOne(input string name, input int a, input int b, input int expRes,
                        input int expSign, input int expLat);
    int lat, bc;
    doStart(a, b);
    waitDone(lat, bc);
    check({name, "_lat"}, 32'(lat), 32'(expLat));
    check({name, "_busy_cycles"}, 32'(bc), 32'(expLat));
    check({name, "_result"}, 32'(result), 32'(expRes));
    check({name, "_sign"}, 32'(sign), 32'(expSign));
    check({name, "_model"}, 32'(resM), 32'(expRes));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, doneSeen;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    @(negedge clk);
    chkEn = 1'b1;
    // Reset pulled together with start: reset wins.
    start = 1'b1;
    A = 8'd9;
    @(negedge clk);
    start = 1'b0;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", 32'(result), 0);
    check("reset_sign", 32'(sign), 0);
    rst_n = 1'b1;
    @(negedge clk);

    runOne("a200_b55", 200, 55, 145, 0, 5);
    @(negedge clk);
    runOne("a55_b200", 55, 200, 145, 1, 9);
    @(negedge clk);
`ifdef ABS_DIFF_EQ_SHORTCUT_EN
    runOne("eq_5a", 8'h5A, 8'h5A, 0, 0, 0);
`else
    runOne("eq_5a", 8'h5A, 8'h5A, 0, 0, 5);
`endif
    @(negedge clk);

    // Back-to-back: second start issued while done is high.
    doStart(255, 0);
    waitDone(lat, bc);
    check("b2b_first_result", 32'(result), 255);
    check("b2b_first_sign", 32'(sign), 0);
    doStart(0, 255);
    check("b2b_no_gap_busy", 32'(busy), 1);
    waitDone(lat, bc);
    check("b2b_second_result", 32'(result), 255);
    check("b2b_second_sign", 32'(sign), 1);
    check("b2b_second_lat", 32'(lat), 9);
    @(negedge clk);

    // Start during busy is ignored.
    doStart(100, 30);
    @(negedge clk);
    doStart(1, 2);
    waitDone(lat, bc);
    check("ignore_start_result", 32'(result), 70);
    check("ignore_start_sign", 32'(sign), 0);
    @(negedge clk);

    // Reset mid-operation abandons it without a done pulse.
    doStart(100, 30);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_busy", 32'(busy), 0);
    check("midreset_result", 32'(result), 0);
    doneSeen = 0;
    repeat (12) begin
      if (done === 1'b1) doneSeen++;
      @(negedge clk);
    end
    check("midreset_no_done", 32'(doneSeen), 0);

    // Random traffic: starts at any time, equal/extreme operands, occasional reset.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      start = ($urandom_range(0, 2) == 0);
      A = W'($urandom_range(0, 255));
      B = W'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0: B = A;
        1: begin A = '1; B = '0; end
        2: begin A = '0; B = '1; end
        default: ;
      endcase
      @(negedge clk);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
